// File: rtl/spi_flash_responder.sv
// SPI NOR flash responder (mode 3): READ/FREAD/PP/RSTEN-RST served from a byte-wide memory port.
// Define SPI_RESP_WREN_EN to add the write-enable latch with WREN (0x06) and RDSR (0x05).
module spi_flash_responder #(
    parameter int ADDR_W     = 22,
    parameter int DUMMY_CLKS = 8,
    parameter int PAGE_W     = 8
) (
    input  logic              interfaceClk,
    input  logic              reset_n,
    input  logic              MCLK,
    input  logic              MOSI,
    input  logic              CS_n,
    output logic              MISO,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data,
    output logic              busy,
    output logic              soft_rst
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, IGNORE} state_t;
    typedef enum logic [1:0] {OP_READ, OP_FREAD, OP_PP} op_t;

    state_t state;
    op_t    op;

    logic [1:0]        mclkSync, mosiSync, csSync;
    logic              mclkPrev, mclkRise, mclkFall;
    logic              needHigh, armed, rdValid;
    logic [4:0]        bitCnt;
    logic [2:0]        outCnt;
    logic [ADDR_W-2:0] shiftIn;
    logic [7:0]        shiftOut;
    logic [ADDR_W-1:0] rxWord;
    logic [7:0]        rxByte;
    logic [ADDR_W-1:0] pageNext;
`ifdef SPI_RESP_WREN_EN
    logic              wel, ppExec, statusMode;
    logic [7:0]        status;
    assign status = {6'b0, wel, 1'b0};
`endif

    // Word as it will stand once the bit on the current rise is shifted in.
    assign rxWord   = {shiftIn, mosiSync[1]};
    assign rxByte   = rxWord[7:0];
    assign pageNext = {mem_addr[ADDR_W-1:PAGE_W], mem_addr[PAGE_W-1:0] + 1'b1};

    // NOTE: synchroniser flops are deliberately not reset so they keep tracking the pins during reset;
    // that lets IDLE tell a CS_n still held low from a genuine fresh falling edge.
    always_ff @(posedge interfaceClk) begin
        mclkSync <= {mclkSync[0], MCLK};
        mosiSync <= {mosiSync[0], MOSI};
        csSync   <= {csSync[0], CS_n};
        mclkPrev <= mclkSync[1];
    end

    always_ff @(posedge interfaceClk) begin
        if (!reset_n) begin
            state       <= IDLE;
            op          <= OP_READ;
            MISO        <= 1'b0;
            mem_addr    <= '0;
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= 8'h00;
            busy        <= 1'b0;
            soft_rst    <= 1'b0;
            mclkRise    <= 1'b0;
            mclkFall    <= 1'b0;
            needHigh    <= 1'b1;
            armed       <= 1'b0;
            rdValid     <= 1'b0;
            bitCnt      <= '0;
            outCnt      <= '0;
            shiftIn     <= '0;
            shiftOut    <= 8'h00;
`ifdef SPI_RESP_WREN_EN
            wel         <= 1'b0;
            ppExec      <= 1'b0;
            statusMode  <= 1'b0;
`endif
        end else begin
            mclkRise  <= mclkSync[1] & ~mclkPrev;
            mclkFall  <= ~mclkSync[1] & mclkPrev;
            busy      <= ~csSync[1];
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            soft_rst  <= 1'b0;
            rdValid   <= mem_rd_en;
            if (rdValid)
                shiftOut <= mem_rd_data;
            // Page-local advance happens right after the write strobe has used the old address.
            if (mem_wr_en)
                mem_addr <= pageNext;

            if (csSync[1]) begin
                state    <= IDLE;
                MISO     <= 1'b0;
                bitCnt   <= '0;
                outCnt   <= '0;
                needHigh <= 1'b0;
`ifdef SPI_RESP_WREN_EN
                if (ppExec)
                    wel <= 1'b0;
                ppExec <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: if (!needHigh) begin
                        state  <= CMD;
                        bitCnt <= '0;
                    end
                    CMD: if (mclkRise) begin
                        shiftIn <= rxWord[ADDR_W-2:0];
                        bitCnt  <= bitCnt + 1'b1;
                        if (bitCnt == 5'd7) begin
                            bitCnt <= '0;
                            armed  <= 1'b0;
                            state  <= IGNORE;
                            case (rxByte)
                                8'h03: begin op <= OP_READ;  state <= ADDR; end
                                8'h0B: begin op <= OP_FREAD; state <= ADDR; end
`ifdef SPI_RESP_WREN_EN
                                8'h02: if (wel) begin
                                    op <= OP_PP; state <= ADDR; ppExec <= 1'b1;
                                end
                                8'h06: wel <= 1'b1;
                                8'h05: begin
                                    shiftOut   <= status;
                                    statusMode <= 1'b1;
                                    outCnt     <= '0;
                                    state      <= RD_DATA;
                                end
`else
                                8'h02: begin op <= OP_PP; state <= ADDR; end
`endif
                                8'h66: armed <= 1'b1;
                                8'h99: if (armed) begin
                                    soft_rst <= 1'b1;
`ifdef SPI_RESP_WREN_EN
                                    wel      <= 1'b0;
`endif
                                end
                                default: ;
                            endcase
                        end
                    end
                    ADDR: if (mclkRise) begin
                        shiftIn <= rxWord[ADDR_W-2:0];
                        bitCnt  <= bitCnt + 1'b1;
                        if (bitCnt == 5'd23) begin
                            bitCnt   <= '0;
                            outCnt   <= '0;
                            mem_addr <= rxWord;
`ifdef SPI_RESP_WREN_EN
                            statusMode <= 1'b0;
`endif
                            if (op == OP_PP)
                                state <= WR_DATA;
                            else if (op == OP_FREAD && DUMMY_CLKS > 0)
                                state <= DUMMY;
                            else begin
                                mem_rd_en <= 1'b1;
                                state     <= RD_DATA;
                            end
                        end
                    end
                    DUMMY: if (mclkRise) begin
                        bitCnt <= bitCnt + 1'b1;
                        if (int'(bitCnt) == DUMMY_CLKS - 1) begin
                            bitCnt    <= '0;
                            mem_rd_en <= 1'b1;
                            state     <= RD_DATA;
                        end
                    end
                    RD_DATA: if (mclkFall) begin
                        MISO     <= shiftOut[7];
                        shiftOut <= {shiftOut[6:0], 1'b0};
                        outCnt   <= outCnt + 1'b1;
                        if (outCnt == 3'd7) begin
`ifdef SPI_RESP_WREN_EN
                            if (statusMode)
                                shiftOut <= status;
                            else begin
                                mem_addr  <= mem_addr + 1'b1;
                                mem_rd_en <= 1'b1;
                            end
`else
                            mem_addr  <= mem_addr + 1'b1;
                            mem_rd_en <= 1'b1;
`endif
                        end
                    end
                    WR_DATA: if (mclkRise) begin
                        shiftIn <= rxWord[ADDR_W-2:0];
                        bitCnt  <= bitCnt + 1'b1;
                        if (bitCnt == 5'd7) begin
                            bitCnt      <= '0;
                            mem_wr_data <= rxByte;
                            mem_wr_en   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: SPI master driver, sparse memory model, pulse/strobe logs.
// Define SPI_RESP_WREN_EN to also exercise the WREN/RDSR feature.
module tb_spi_flash_responder;

    localparam int ADDR_W = 22;
    localparam int HALF   = 8;

    logic              interfaceClk = 1'b0;
    logic              reset_n = 1'b0;
    logic              MCLK = 1'b1;
    logic              MOSI = 1'b0;
    logic              CS_n = 1'b1;
    logic              MISO;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [7:0]        mem_rd_data = 8'h00;
    logic              mem_wr_en;
    logic [7:0]        mem_wr_data;
    logic              busy;
    logic              soft_rst;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [int];
    int         rdLog [$];
    int         wrAddrLog [$];
    logic [7:0] wrDataLog [$];
    int         softRstCnt = 0;

    spi_flash_responder #(.ADDR_W(ADDR_W), .DUMMY_CLKS(8), .PAGE_W(8)) dut (
        .interfaceClk(interfaceClk), .reset_n(reset_n), .MCLK(MCLK), .MOSI(MOSI), .CS_n(CS_n),
        .MISO(MISO), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .busy(busy), .soft_rst(soft_rst)
    );

    always #5 interfaceClk = ~interfaceClk;

    // Memory with one-cycle read latency, plus logs of every strobe.
    always @(posedge interfaceClk) begin
        if (mem_rd_en) begin
            mem_rd_data <= mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 8'h00;
            rdLog.push_back(int'(mem_addr));
        end
        if (mem_wr_en) begin
            mem[int'(mem_addr)] = mem_wr_data;
            wrAddrLog.push_back(int'(mem_addr));
            wrDataLog.push_back(mem_wr_data);
        end
        if (soft_rst)
            softRstCnt++;
    end

    task automatic clear_logs();
        rdLog.delete();
        wrAddrLog.delete();
        wrDataLog.delete();
    endtask

    task automatic cs_low();
        @(negedge interfaceClk);
        CS_n = 1'b0;
        repeat (4) @(negedge interfaceClk);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge interfaceClk);
        CS_n = 1'b1;
        repeat (8) @(negedge interfaceClk);
    endtask

    // Mode 3: master shifts MOSI out on the fall and samples MISO just before the rise.
    task automatic spi_bits(input logic [7:0] txb, input int n, output logic [7:0] rxb);
        rxb = 8'h00;
        for (int i = 0; i < n; i++) begin
            MCLK = 1'b0;
            MOSI = txb[7-i];
            repeat (HALF) @(negedge interfaceClk);
            rxb  = {rxb[6:0], MISO};
            MCLK = 1'b1;
            repeat (HALF) @(negedge interfaceClk);
        end
    endtask

    task automatic spi_byte(input logic [7:0] txb, output logic [7:0] rxb);
        spi_bits(txb, 8, rxb);
    endtask

    task automatic cmd_frame(input logic [7:0] opcode);
        logic [7:0] dummy;
        cs_low();
        spi_byte(opcode, dummy);
        cs_high();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (5) @(negedge interfaceClk);
        checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL reset_miso got=%b exp=0", MISO); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) begin
            errors++; $display("FAIL reset_strobes got rd=%b wr=%b exp=0", mem_rd_en, mem_wr_en); end
        checks++; if (mem_wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data got=%h exp=00", mem_wr_data); end
        checks++; if (busy !== 1'b0 || soft_rst !== 1'b0) begin
            errors++; $display("FAIL reset_busy_srst got busy=%b srst=%b exp=0", busy, soft_rst); end
        reset_n = 1'b1;
        repeat (6) @(negedge interfaceClk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_read();
        logic [7:0] rx0, rx1, dummy;
        mem[32'h10] = 8'hA5;
        mem[32'h11] = 8'h3C;
        clear_logs();
        cs_low();
        spi_byte(8'h03, dummy);
        spi_byte(8'h00, dummy);
        spi_byte(8'h00, dummy);
        spi_byte(8'h10, dummy);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL read_busy got=%b exp=1", busy); end
        spi_byte(8'h00, rx0);
        spi_byte(8'h00, rx1);
        cs_high();
        checks++; if (rx0 !== 8'hA5) begin errors++; $display("FAIL read_byte0 got=%h exp=a5", rx0); end
        checks++; if (rx1 !== 8'h3C) begin errors++; $display("FAIL read_byte1 got=%h exp=3c", rx1); end
        checks++; if (rdLog.size() < 2 || rdLog[0] != 32'h10 || rdLog[1] != 32'h11) begin
            errors++; $display("FAIL read_strobes got n=%0d first=%h exp 10,11", rdLog.size(),
                               rdLog.size() > 0 ? rdLog[0] : -1); end
        checks++; if (wrAddrLog.size() != 0) begin errors++; $display("FAIL read_no_write got=%0d exp=0", wrAddrLog.size()); end
        checks++; if (MISO !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL read_idle got miso=%b busy=%b exp=0", MISO, busy); end
    endtask

    task automatic test_fread();
        logic [7:0] rx0, rx1, dummy;
        mem[32'h3FFFFF] = 8'h81;
        mem[32'h0]      = 8'h7E;
        clear_logs();
        cs_low();
        spi_byte(8'h0B, dummy);
        spi_byte(8'h3F, dummy);
        spi_byte(8'hFF, dummy);
        spi_byte(8'hFF, dummy);
        spi_byte(8'hFF, dummy);
        checks++; if (rdLog.size() != 1) begin errors++; $display("FAIL fread_dummy_strobe got=%0d exp=1", rdLog.size()); end
        spi_byte(8'h00, rx0);
        spi_byte(8'h00, rx1);
        cs_high();
        checks++; if (rx0 !== 8'h81) begin errors++; $display("FAIL fread_byte0 got=%h exp=81", rx0); end
        checks++; if (rx1 !== 8'h7E) begin errors++; $display("FAIL fread_wrap_byte got=%h exp=7e", rx1); end
        checks++; if (rdLog.size() < 2 || rdLog[0] != 32'h3FFFFF || rdLog[1] != 0) begin
            errors++; $display("FAIL fread_addr_wrap got n=%0d exp 3fffff,0", rdLog.size()); end
    endtask

    task automatic test_page_program();
        logic [7:0] dummy;
`ifdef SPI_RESP_WREN_EN
        cmd_frame(8'h06);
`endif
        clear_logs();
        cs_low();
        spi_byte(8'h02, dummy);
        spi_byte(8'h00, dummy);
        spi_byte(8'h01, dummy);
        spi_byte(8'hFE, dummy);
        spi_byte(8'h11, dummy);
        spi_byte(8'h22, dummy);
        spi_byte(8'h33, dummy);
        spi_bits(8'h44, 5, dummy);
        cs_high();
        checks++; if (wrAddrLog.size() != 3) begin errors++; $display("FAIL pp_write_count got=%0d exp=3", wrAddrLog.size()); end
        else begin
            checks++; if (wrAddrLog[0] != 32'h1FE || wrAddrLog[1] != 32'h1FF || wrAddrLog[2] != 32'h100) begin
                errors++; $display("FAIL pp_page_wrap got=%h,%h,%h exp=1fe,1ff,100",
                                   wrAddrLog[0], wrAddrLog[1], wrAddrLog[2]); end
            checks++; if (wrDataLog[0] !== 8'h11 || wrDataLog[1] !== 8'h22 || wrDataLog[2] !== 8'h33) begin
                errors++; $display("FAIL pp_data got=%h,%h,%h exp=11,22,33",
                                   wrDataLog[0], wrDataLog[1], wrDataLog[2]); end
        end
        checks++; if (rdLog.size() != 0) begin errors++; $display("FAIL pp_no_read got=%0d exp=0", rdLog.size()); end
    endtask

    task automatic test_soft_reset();
        int base;
        base = softRstCnt;
        cmd_frame(8'h99);
        checks++; if (softRstCnt != base) begin errors++; $display("FAIL srst_unarmed got=%0d exp=%0d", softRstCnt, base); end
        cmd_frame(8'h66);
        cmd_frame(8'h99);
        checks++; if (softRstCnt != base + 1) begin errors++; $display("FAIL srst_pulse got=%0d exp=%0d", softRstCnt, base + 1); end
        cmd_frame(8'h66);
        cmd_frame(8'h05);
        cmd_frame(8'h99);
        checks++; if (softRstCnt != base + 1) begin errors++; $display("FAIL srst_disarmed got=%0d exp=%0d", softRstCnt, base + 1); end
    endtask

    task automatic test_cs_abort();
        logic [7:0] rx, dummy;
        clear_logs();
        cs_low();
        spi_byte(8'h03, dummy);
        spi_byte(8'h00, dummy);
        spi_bits(8'h00, 4, dummy);
        cs_high();
        checks++; if (busy !== 1'b0 || MISO !== 1'b0) begin
            errors++; $display("FAIL abort_idle got busy=%b miso=%b exp=0", busy, MISO); end
        checks++; if (rdLog.size() != 0) begin errors++; $display("FAIL abort_no_read got=%0d exp=0", rdLog.size()); end
        cs_low();
        spi_byte(8'h03, dummy);
        spi_byte(8'h00, dummy);
        spi_byte(8'h00, dummy);
        spi_byte(8'h00, dummy);
        spi_byte(8'h00, rx);
        cs_high();
        checks++; if (rx !== 8'h7E) begin errors++; $display("FAIL abort_next_read got=%h exp=7e", rx); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] rx, dummy;
        clear_logs();
        cs_low();
        spi_byte(8'h03, dummy);
        spi_byte(8'h00, dummy);
        @(negedge interfaceClk);
        reset_n = 1'b0;
        repeat (3) @(negedge interfaceClk);
        reset_n = 1'b1;
        spi_byte(8'h00, dummy);
        spi_byte(8'h10, dummy);
        spi_byte(8'h00, rx);
        checks++; if (rdLog.size() != 0 || rx !== 8'h00) begin
            errors++; $display("FAIL rst_midframe_resumed got reads=%0d rx=%h exp 0,00", rdLog.size(), rx); end
        cs_high();
        cs_low();
        spi_byte(8'h03, dummy);
        spi_byte(8'h00, dummy);
        spi_byte(8'h00, dummy);
        spi_byte(8'h11, dummy);
        spi_byte(8'h00, rx);
        cs_high();
        checks++; if (rx !== 8'h3C) begin errors++; $display("FAIL rst_midframe_fresh got=%h exp=3c", rx); end
    endtask

`ifdef SPI_RESP_WREN_EN
    task automatic test_wren();
        logic [7:0] rx, dummy;
        clear_logs();
        cs_low();
        spi_byte(8'h02, dummy); spi_byte(8'h00, dummy); spi_byte(8'h00, dummy); spi_byte(8'h20, dummy);
        spi_byte(8'hAA, dummy);
        cs_high();
        checks++; if (wrAddrLog.size() != 0) begin errors++; $display("FAIL wren_pp_blocked got=%0d exp=0", wrAddrLog.size()); end
        cmd_frame(8'h06);
        cs_low();
        spi_byte(8'h05, dummy);
        spi_byte(8'h00, rx);
        checks++; if (rx !== 8'h02) begin errors++; $display("FAIL rdsr_wel_set got=%h exp=02", rx); end
        spi_byte(8'h00, rx);
        checks++; if (rx !== 8'h02) begin errors++; $display("FAIL rdsr_repeat got=%h exp=02", rx); end
        cs_high();
        cs_low();
        spi_byte(8'h02, dummy); spi_byte(8'h00, dummy); spi_byte(8'h00, dummy); spi_byte(8'h30, dummy);
        spi_byte(8'hAA, dummy);
        cs_high();
        checks++; if (wrAddrLog.size() != 1 || wrDataLog[0] !== 8'hAA) begin
            errors++; $display("FAIL wren_pp_write got n=%0d exp one write of aa", wrAddrLog.size()); end
        cs_low();
        spi_byte(8'h05, dummy);
        spi_byte(8'h00, rx);
        cs_high();
        checks++; if (rx !== 8'h00) begin errors++; $display("FAIL rdsr_wel_cleared got=%h exp=00", rx); end
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_fread();
        test_page_program();
        test_soft_reset();
        test_cs_abort();
        test_reset_midframe();
`ifdef SPI_RESP_WREN_EN
        test_wren();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
